// File: rtl/regfile_scoreboard.sv
// 32 x DATA_WIDTH architectural register file with write-through bypass and a
// per-register busy scoreboard for long-latency results; register 0 reads as zero.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter bit FORWARD    = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [4:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_reserve,
    input  logic [4:0]            ctrl_reserveReg,
    input  logic [4:0]            ctrl_readRegA,
    input  logic [4:0]            ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic [5:0]            busy_count
);

    logic [DATA_WIDTH-1:0] regs_q [1:31];
    logic [DATA_WIDTH-1:0] regs_d [1:31];
    logic [31:0]           busy_q;
    logic [31:0]           busy_d;
    logic [5:0]            busy_count_q;
    logic [5:0]            busy_count_d;

    logic                  write_valid;
    logic                  fwd_hit_a;
    logic                  fwd_hit_b;

    assign write_valid = ctrl_writeEnable && (ctrl_writeReg != 5'd0);

    // Next-state: write commits and clears busy, then a reserve re-sets it.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < 32; i++) begin
            if (write_valid && (ctrl_writeReg == 5'(i))) begin
                regs_d[i] = data_writeReg;
                busy_d[i] = 1'b0;
            end
        end
        for (int i = 1; i < 32; i++) begin
            if (ctrl_reserve && (ctrl_reserveReg == 5'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 1; i < 32; i++) begin
            busy_count_d = busy_count_d + 6'(busy_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign fwd_hit_a = FORWARD && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_hit_b = FORWARD && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);

    // Index 0 never matches the stored-register loop, so it falls through to zero.
    always_comb begin
        data_readRegA = '0;
        for (int i = 1; i < 32; i++) begin
            if (ctrl_readRegA == 5'(i)) begin
                data_readRegA = regs_q[i];
            end
        end
        if (fwd_hit_a && (ctrl_readRegA != 5'd0)) begin
            data_readRegA = data_writeReg;
        end
    end

    always_comb begin
        data_readRegB = '0;
        for (int i = 1; i < 32; i++) begin
            if (ctrl_readRegB == 5'(i)) begin
                data_readRegB = regs_q[i];
            end
        end
        if (fwd_hit_b && (ctrl_readRegB != 5'd0)) begin
            data_readRegB = data_writeReg;
        end
    end

    // A result arriving this cycle releases the hazard immediately when bypassing.
    assign busy_A     = busy_q[ctrl_readRegA] & ~fwd_hit_a;
    assign busy_B     = busy_q[ctrl_readRegB] & ~fwd_hit_b;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard: a bypassing and a non-bypassing
// instance share stimulus and are compared against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        ctrl_reserve;
   logic [4:0]  ctrl_reserveReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;

   logic [31:0] readAF1, readBF1, readAF0, readBF0;
   logic        busyAF1, busyBF1, busyAF0, busyBF0;
   logic [5:0]  countF1, countF0;

   int checks = 0;
   int failures = 0;

   logic [31:0] modelRegs [32];
   bit          modelBusy [32];

   // Free-running 10-time-unit clock
   always #5 clock = ~clock;

   regfile_scoreboard #(.DATA_WIDTH(32), .FORWARD(1'b1)) dutFwd (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
      .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(readAF1), .data_readRegB(readBF1),
      .busy_A(busyAF1), .busy_B(busyBF1), .busy_count(countF1)
   );

   regfile_scoreboard #(.DATA_WIDTH(32), .FORWARD(1'b0)) dutNoFwd (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
      .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(readAF0), .data_readRegB(readBF0),
      .busy_A(busyAF0), .busy_B(busyBF0), .busy_count(countF0)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at t=%0t", tag, actual, expected, $time);
      end
   endtask

   // Architectural read value as seen by decode this cycle
   function automatic logic [31:0] expRead(input bit fwd, input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (fwd && ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
      return modelRegs[idx];
   endfunction

   // Hazard flag: outstanding reservation unless the result is arriving now with bypass
   function automatic logic [31:0] expBusy(input bit fwd, input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (fwd && ctrl_writeEnable && ctrl_writeReg == idx) return 32'h0;
      return {31'h0, modelBusy[idx]};
   endfunction

   function automatic logic [31:0] expCount();
      int n = 0;
      foreach (modelBusy[i]) if (modelBusy[i]) n++;
      return n;
   endfunction

   // Compare every output of both instances against the model
   task automatic compareAll();
      checkOutput("fwd_readA",   readAF1,            expRead(1'b1, ctrl_readRegA));
      checkOutput("fwd_readB",   readBF1,            expRead(1'b1, ctrl_readRegB));
      checkOutput("fwd_busyA",   {31'h0, busyAF1},   expBusy(1'b1, ctrl_readRegA));
      checkOutput("fwd_busyB",   {31'h0, busyBF1},   expBusy(1'b1, ctrl_readRegB));
      checkOutput("fwd_count",   {26'h0, countF1},   expCount());
      checkOutput("nofwd_readA", readAF0,            expRead(1'b0, ctrl_readRegA));
      checkOutput("nofwd_readB", readBF0,            expRead(1'b0, ctrl_readRegB));
      checkOutput("nofwd_busyA", {31'h0, busyAF0},   expBusy(1'b0, ctrl_readRegA));
      checkOutput("nofwd_busyB", {31'h0, busyBF0},   expBusy(1'b0, ctrl_readRegB));
      checkOutput("nofwd_count", {26'h0, countF0},   expCount());
   endtask

   // Clock-edge behaviour of the architectural state
   task automatic updateModel();
      if (!ctrl_reset) begin
         foreach (modelRegs[i]) begin
            modelRegs[i] = 32'h0;
            modelBusy[i] = 1'b0;
         end
      end else begin
         if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            modelRegs[ctrl_writeReg] = data_writeReg;
            modelBusy[ctrl_writeReg] = 1'b0;
         end
         if (ctrl_reserve && ctrl_reserveReg != 5'd0) modelBusy[ctrl_reserveReg] = 1'b1;
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, then advance past the edge
   task automatic applyStimulus(input logic rst, input logic wen, input logic [4:0] wr,
                                input logic [31:0] wd, input logic res, input logic [4:0] rr,
                                input logic [4:0] ra, input logic [4:0] rb);
      ctrl_reset       = rst;
      ctrl_writeEnable = wen;
      ctrl_writeReg    = wr;
      data_writeReg    = wd;
      ctrl_reserve     = res;
      ctrl_reserveReg  = rr;
      ctrl_readRegA    = ra;
      ctrl_readRegB    = rb;
      #2;
      compareAll();
      @(posedge clock);
      updateModel();
      #1;
   endtask

   function automatic logic [4:0] pickReg();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   // Directed test-plan sequence followed by randomized traffic
   initial begin
      foreach (modelRegs[i]) begin
         modelRegs[i] = 32'h0;
         modelBusy[i] = 1'b0;
      end
      ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
      ctrl_reserve = 1'b0; ctrl_reserveReg = '0; ctrl_readRegA = '0; ctrl_readRegB = '0;
      @(posedge clock);
      #1;

      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));

      applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0);
      checkOutput("r5_written", readAF0, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);
      checkOutput("r0_discard", readAF1, 32'h0);

      applyStimulus(1'b1, 1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 5'd7, 5'd7);
      ctrl_readRegA = 5'd7; ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hCAFEF00D;
      #2;
      checkOutput("bypass_fwd",   readAF1, 32'hCAFEF00D);
      checkOutput("bypass_nofwd", readAF0, 32'h00000001);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd7);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9);
      checkOutput("count_one", {26'h0, countF1}, 32'd1);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd9);
      checkOutput("count_two", {26'h0, countF1}, 32'd2);
      checkOutput("busyA_r3",  {31'h0, busyAF1}, 32'd1);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h000000AA, 1'b0, 5'd0, 5'd3, 5'd9);
      checkOutput("release_count", {26'h0, countF1}, 32'd1);

      applyStimulus(1'b1, 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd12, 5'd12, 5'd12);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd12, 5'd0);
      checkOutput("wr_res_data", readAF0, 32'h0BADF00D);
      checkOutput("wr_res_busy", {31'h0, busyAF0}, 32'd1);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd12, 5'd9);

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd4, 32'h00000055, 1'b0, 5'd0, 5'd4, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h00000066, 1'b1, 5'd4, 5'd4, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd12);
      checkOutput("reset_r4",    readAF1, 32'h0);
      checkOutput("reset_count", {26'h0, countF1}, 32'd0);

      for (int n = 0; n < 800; n++) begin
         applyStimulus(($urandom_range(0, 60) != 0), $urandom_range(0, 1) == 1, pickReg(), $urandom(),
                       $urandom_range(0, 2) == 0, pickReg(), pickReg(), pickReg());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file for the processor: 32 × 32-bit registers, one write port, two combinational read ports (each a 32:1 selection of register contents), write-through bypass, and a per-register busy scoreboard for long-latency (multdiv) results. Sits between writeback (write port, scoreboard release) and decode (read ports, hazard/stall logic). Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, register width; all data ports use this width.
- FORWARD, 1, 1 = same-cycle write-through bypass on reads; 0 = reads return stored value only.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  reset, synchronous, active-low.
- ctrl_writeEnable  in  1  commit data_writeReg to ctrl_writeReg this edge.
- ctrl_writeReg  in  5  write destination index.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_reserve  in  1  mark ctrl_reserveReg busy (long-latency op issued).
- ctrl_reserveReg  in  5  register to reserve.
- ctrl_readRegA  in  5  read port A index.
- ctrl_readRegB  in  5  read port B index.
- data_readRegA  out  DATA_WIDTH  port A data (combinational).
- data_readRegB  out  DATA_WIDTH  port B data (combinational).
- busy_A  out  1  port A register has an outstanding reservation.
- busy_B  out  1  port B register has an outstanding reservation.
- busy_count  out  6  registered count of busy bits set (0–31).

## Operation
- Storage: regs[1..31] flops; regs[0] is constant 0, never stored.
- Write: on edge with ctrl_writeEnable=1 and ctrl_writeReg≠0, regs[ctrl_writeReg] ← data_writeReg. Writes to 0 discarded.
- Read: data_readRegX = 0 if index 0; else if FORWARD=1 and ctrl_writeEnable=1 and ctrl_writeReg==index, data_writeReg; else regs[index]. Both ports independent; A and B may name the same register.
- Scoreboard: busy[1..31] bits; busy[0] constant 0.
  - Write to r (r≠0) clears busy[r] at the edge.
  - ctrl_reserve=1 with ctrl_reserveReg≠0 sets busy[r] at the edge.
  - Same edge, same r, both write and reserve: busy[r] ends 1 (set after clear; new op outstanding). Write data still committed.
  - Reserve of an already-busy register: stays 1, no error.
  - Reserve of r0: ignored.
- busy_X = busy[index] & ~(FORWARD & ctrl_writeEnable & ctrl_writeReg==index); i.e. a result arriving this cycle releases the hazard combinationally when bypass is enabled. index 0 → 0.
- busy_count: registered popcount of next-state busy vector; equals number of set busy bits after each edge.

## Timing
- Reset (ctrl_reset=0 at an edge): all regs[1..31] ← 0, all busy ← 0, busy_count ← 0. Write and reserve inputs ignored that edge. Applies mid-operation; no pending state survives.
- Post-reset outputs: data_readRegA/B = 0 (or bypass value if FORWARD=1 and writing), busy_A/B = 0, busy_count = 0.
- Write latency: stored value visible to read ports the cycle after the edge; with FORWARD=1 visible same cycle combinationally.
- Reserve latency: busy_X asserts the cycle after the reserving edge; busy_count updates at the same edge.
- Release latency: busy cleared at write edge; with FORWARD=1 busy_X drops in the write cycle itself.
- No handshake stalls inside the block; decode stalls while busy_X=1.

## Test plan
- Reset then read all 32 indices on both ports -> every data = 0, busy_A = busy_B = 0, busy_count = 0.
- Write r5 = 0xDEADBEEF, next cycle read A=5, B=0 -> A = 0xDEADBEEF, B = 0; write r0 = 0x12345678 -> read r0 = 0.
- FORWARD=1: in same cycle write r7 = 0xCAFEF00D with readA=7 (r7 previously 0x1) -> data_readRegA = 0xCAFEF00D that cycle; FORWARD=0 -> 0x1 that cycle, 0xCAFEF00D next.
- Reserve r3, r9 on consecutive edges -> busy_count 1 then 2; readA=3 -> busy_A=1; write r3 = 0xAA -> with FORWARD=1 busy_A=0 in write cycle, busy_count=1 after edge.
- Simultaneous write and reserve of r12 -> r12 holds new data, busy[12]=1, busy_count +1 (if previously clear); reserve r0 -> busy_count unchanged.
- Reserve r4, write r4 = 0x55, then drive ctrl_reset=0 with writeEnable=1 to r4 = 0x66 -> after edge r4 = 0, busy_count = 0, busy_A(4) = 0.
